axi4_lite_master: RTL and testbench

AXI4-Lite bus master that turns single-cycle read/write commands from local logic into complete AXI4-Lite transactions. It sits between application logic (register-init sequencers, test drivers, control FSMs) and an AXI4-Lite interconnect or slave. It presents a simple command interface: pulse a strobe with address/data, wait for the idle flag, collect the response. Read and write paths are independent and may run concurrently.

---
 rtl/axi4_lite_master.sv | 156 +++++++++++++++
 tb/tb_axi4_lite_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns one-cycle AMCI read/write strobes into full AXI4-Lite transactions, with independent read and write engines.
// Latency: 3 cycles strobe-to-idle against a zero-wait slave; VALIDs are held until their handshake, and strobes arriving while an engine is busy are dropped.
module axi4_lite_master (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] AMCI_WADDR,
   input  logic [31:0] AMCI_WDATA,
   input  logic        AMCI_WRITE,
   output logic        AMCI_WIDLE,
   output logic [1:0]  AMCI_WRESP,
   input  logic [31:0] AMCI_RADDR,
   input  logic        AMCI_READ,
   output logic        AMCI_RIDLE,
   output logic [31:0] AMCI_RDATA,
   output logic [1:0]  AMCI_RRESP,
   output logic [31:0] AXI_AWADDR,
   output logic        AXI_AWVALID,
   output logic [2:0]  AXI_AWPROT,
   input  logic        AXI_AWREADY,
   output logic [31:0] AXI_WDATA,
   output logic        AXI_WVALID,
   output logic [3:0]  AXI_WSTRB,
   input  logic        AXI_WREADY,
   input  logic [1:0]  AXI_BRESP,
   input  logic        AXI_BVALID,
   output logic        AXI_BREADY,
   output logic [31:0] AXI_ARADDR,
   output logic        AXI_ARVALID,
   output logic [2:0]  AXI_ARPROT,
   input  logic        AXI_ARREADY,
   input  logic [31:0] AXI_RDATA,
   input  logic [1:0]  AXI_RRESP,
   input  logic        AXI_RVALID,
   output logic        AXI_RREADY
);

   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

   w_state_t    w_state, w_state_n;
   r_state_t    r_state, r_state_n;
   logic [31:0] awaddr_n, wdata_n, araddr_n, rdata_n;
   logic        awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
   logic [1:0]  wresp_n, rresp_n;

   assign AXI_AWPROT = 3'b000;
   assign AXI_ARPROT = 3'b000;
   assign AXI_WSTRB  = 4'hF;
   assign AMCI_WIDLE = (w_state == W_IDLE);
   assign AMCI_RIDLE = (r_state == R_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state     <= W_IDLE;
         r_state     <= R_IDLE;
         AXI_AWADDR  <= 32'h0;
         AXI_WDATA   <= 32'h0;
         AXI_ARADDR  <= 32'h0;
         AXI_AWVALID <= 1'b0;
         AXI_WVALID  <= 1'b0;
         AXI_BREADY  <= 1'b0;
         AXI_ARVALID <= 1'b0;
         AXI_RREADY  <= 1'b0;
         AMCI_WRESP  <= 2'b00;
         AMCI_RDATA  <= 32'h0;
         AMCI_RRESP  <= 2'b00;
      end else begin
         w_state     <= w_state_n;
         r_state     <= r_state_n;
         AXI_AWADDR  <= awaddr_n;
         AXI_WDATA   <= wdata_n;
         AXI_ARADDR  <= araddr_n;
         AXI_AWVALID <= awvalid_n;
         AXI_WVALID  <= wvalid_n;
         AXI_BREADY  <= bready_n;
         AXI_ARVALID <= arvalid_n;
         AXI_RREADY  <= rready_n;
         AMCI_WRESP  <= wresp_n;
         AMCI_RDATA  <= rdata_n;
         AMCI_RRESP  <= rresp_n;
      end
   end

   always_comb begin
      w_state_n = w_state;
      awaddr_n  = AXI_AWADDR;
      wdata_n   = AXI_WDATA;
      awvalid_n = AXI_AWVALID;
      wvalid_n  = AXI_WVALID;
      bready_n  = AXI_BREADY;
      wresp_n   = AMCI_WRESP;
      case (w_state)
         W_IDLE: begin
            if (AMCI_WRITE) begin
               awaddr_n  = AMCI_WADDR;
               wdata_n   = AMCI_WDATA;
               awvalid_n = 1'b1;
               wvalid_n  = 1'b1;
               w_state_n = W_XFER;
            end
         end
         W_XFER: begin
            // AW and W retire independently; a handshake this cycle already counts as done
            if (AXI_AWREADY) awvalid_n = 1'b0;
            if (AXI_WREADY)  wvalid_n  = 1'b0;
            if (!awvalid_n && !wvalid_n) begin
               bready_n  = 1'b1;
               w_state_n = W_RESP;
            end
         end
         W_RESP: begin
            if (AXI_BVALID) begin
               wresp_n   = AXI_BRESP;
               bready_n  = 1'b0;
               w_state_n = W_IDLE;
            end
         end
         default: w_state_n = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_n = r_state;
      araddr_n  = AXI_ARADDR;
      arvalid_n = AXI_ARVALID;
      rready_n  = AXI_RREADY;
      rdata_n   = AMCI_RDATA;
      rresp_n   = AMCI_RRESP;
      case (r_state)
         R_IDLE: begin
            if (AMCI_READ) begin
               araddr_n  = AMCI_RADDR;
               arvalid_n = 1'b1;
               r_state_n = R_ADDR;
            end
         end
         R_ADDR: begin
            if (AXI_ARREADY) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               r_state_n = R_DATA;
            end
         end
         R_DATA: begin
            if (AXI_RVALID) begin
               rdata_n   = AXI_RDATA;
               rresp_n   = AXI_RRESP;
               rready_n  = 1'b0;
               r_state_n = R_IDLE;
            end
         end
         default: r_state_n = R_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a delay-configurable AXI4-Lite slave with a protocol monitor on the negedge,
// plus scenario tasks that queue expected transactions at strobe time and compare them at completion.
module tb_axi4_lite_master;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] AMCI_WADDR, AMCI_WDATA, AMCI_RADDR;
   logic        AMCI_WRITE, AMCI_READ;
   logic        AMCI_WIDLE, AMCI_RIDLE;
   logic [1:0]  AMCI_WRESP, AMCI_RRESP;
   logic [31:0] AMCI_RDATA;
   logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
   logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
   logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
   logic [2:0]  AXI_AWPROT, AXI_ARPROT;
   logic [3:0]  AXI_WSTRB;
   logic [1:0]  AXI_BRESP, AXI_RRESP;

   axi4_lite_master dut (
      .clk(clk), .reset(reset),
      .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WRITE(AMCI_WRITE),
      .AMCI_WIDLE(AMCI_WIDLE), .AMCI_WRESP(AMCI_WRESP),
      .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ), .AMCI_RIDLE(AMCI_RIDLE),
      .AMCI_RDATA(AMCI_RDATA), .AMCI_RRESP(AMCI_RRESP),
      .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWPROT(AXI_AWPROT), .AXI_AWREADY(AXI_AWREADY),
      .AXI_WDATA(AXI_WDATA), .AXI_WVALID(AXI_WVALID), .AXI_WSTRB(AXI_WSTRB), .AXI_WREADY(AXI_WREADY),
      .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
      .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARPROT(AXI_ARPROT), .AXI_ARREADY(AXI_ARREADY),
      .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } txn_t;

   txn_t exp_w[$];
   txn_t exp_r[$];
   txn_t e;
   int   checks, errors;

   // slave configuration (written by the scenario tasks only)
   int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
   logic [1:0]  b_resp_val, r_resp_val;
   logic [31:0] r_data_val;

   // slave state and observations (written by the slave process only)
   int          aw_hs, w_hs, b_hs, ar_hs, r_hs, mon_err;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit          aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire;
   bit          aw_prev, w_prev, ar_prev, bready_prev, rready_prev;
   logic [31:0] aw_prev_addr, w_prev_data, ar_prev_addr;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   logic [2:0]  cap_awprot, cap_arprot;

   // Ready/valid decisions are made on the negedge, so a *_fire flag set here means the handshake happens on the following posedge.
   initial begin
      AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_BRESP = 0;
      AXI_ARREADY = 0; AXI_RVALID = 0; AXI_RDATA = 0; AXI_RRESP = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; mon_err = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_prev = 0; w_prev = 0; ar_prev = 0; bready_prev = 0; rready_prev = 0;
      aw_prev_addr = 0; w_prev_data = 0; ar_prev_addr = 0;
      cap_awaddr = 0; cap_wdata = 0; cap_araddr = 0; cap_wstrb = 0; cap_awprot = 0; cap_arprot = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_ARREADY = 0; AXI_RVALID = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_prev = 0; w_prev = 0; ar_prev = 0; bready_prev = 0; rready_prev = 0;
         end else begin
            if (aw_prev && (aw_fire ? AXI_AWVALID : (!AXI_AWVALID || AXI_AWADDR !== aw_prev_addr))) begin
               mon_err++; $display("protocol violation: AWVALID=%0b AWADDR=%h handshake=%0b at %0t", AXI_AWVALID, AXI_AWADDR, aw_fire, $time);
            end
            if (w_prev && (w_fire ? AXI_WVALID : (!AXI_WVALID || AXI_WDATA !== w_prev_data))) begin
               mon_err++; $display("protocol violation: WVALID=%0b WDATA=%h handshake=%0b at %0t", AXI_WVALID, AXI_WDATA, w_fire, $time);
            end
            if (ar_prev && (ar_fire ? AXI_ARVALID : (!AXI_ARVALID || AXI_ARADDR !== ar_prev_addr))) begin
               mon_err++; $display("protocol violation: ARVALID=%0b ARADDR=%h handshake=%0b at %0t", AXI_ARVALID, AXI_ARADDR, ar_fire, $time);
            end
            if (bready_prev && (b_fire ? AXI_BREADY : !AXI_BREADY)) begin
               mon_err++; $display("protocol violation: BREADY=%0b handshake=%0b at %0t", AXI_BREADY, b_fire, $time);
            end
            if (rready_prev && (r_fire ? AXI_RREADY : !AXI_RREADY)) begin
               mon_err++; $display("protocol violation: RREADY=%0b handshake=%0b at %0t", AXI_RREADY, r_fire, $time);
            end
            if (AXI_BREADY && !(aw_got && w_got)) begin
               mon_err++; $display("protocol violation: BREADY before AW/W done (aw=%0b w=%0b) at %0t", aw_got, w_got, $time);
            end
            // write response
            if (b_fire) begin
               b_fire = 0; AXI_BVALID = 0; aw_got = 0; w_got = 0; b_cnt = 0;
            end else if (aw_got && w_got) begin
               if (b_cnt >= b_delay) begin AXI_BVALID = 1; AXI_BRESP = b_resp_val; end
               b_cnt++;
               if (AXI_BVALID && AXI_BREADY) begin b_fire = 1; b_hs++; end
            end
            if (aw_fire) begin
               aw_fire = 0; AXI_AWREADY = 0; aw_cnt = 0;
            end else if (AXI_AWVALID && !aw_got) begin
               AXI_AWREADY = (aw_cnt >= aw_delay);
               aw_cnt++;
               if (AXI_AWREADY) begin
                  aw_fire = 1; aw_got = 1; aw_hs++; cap_awaddr = AXI_AWADDR; cap_awprot = AXI_AWPROT;
               end
            end
            if (w_fire) begin
               w_fire = 0; AXI_WREADY = 0; w_cnt = 0;
            end else if (AXI_WVALID && !w_got) begin
               AXI_WREADY = (w_cnt >= w_delay);
               w_cnt++;
               if (AXI_WREADY) begin
                  w_fire = 1; w_got = 1; w_hs++; cap_wdata = AXI_WDATA; cap_wstrb = AXI_WSTRB;
               end
            end
            // read data
            if (r_fire) begin
               r_fire = 0; AXI_RVALID = 0; ar_got = 0; r_cnt = 0;
            end else if (ar_got) begin
               if (r_cnt >= r_delay) begin AXI_RVALID = 1; AXI_RDATA = r_data_val; AXI_RRESP = r_resp_val; end
               r_cnt++;
               if (AXI_RVALID && AXI_RREADY) begin r_fire = 1; r_hs++; end
            end
            if (ar_fire) begin
               ar_fire = 0; AXI_ARREADY = 0; ar_cnt = 0;
            end else if (AXI_ARVALID && !ar_got) begin
               AXI_ARREADY = (ar_cnt >= ar_delay);
               ar_cnt++;
               if (AXI_ARREADY) begin
                  ar_fire = 1; ar_got = 1; ar_hs++; cap_araddr = AXI_ARADDR; cap_arprot = AXI_ARPROT;
               end
            end
            aw_prev = AXI_AWVALID; aw_prev_addr = AXI_AWADDR;
            w_prev = AXI_WVALID;   w_prev_data = AXI_WDATA;
            ar_prev = AXI_ARVALID; ar_prev_addr = AXI_ARADDR;
            bready_prev = AXI_BREADY; rready_prev = AXI_RREADY;
         end
      end
   end

   // Called #1 after a posedge; the strobe is sampled on the next posedge (edge 0).
   task automatic drive_cmd(input logic wr, input logic rd, input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
      AMCI_WADDR = wa; AMCI_WDATA = wd; AMCI_RADDR = ra;
      AMCI_WRITE = wr; AMCI_READ = rd;
      @(posedge clk); #1;
      AMCI_WRITE = 0; AMCI_READ = 0;
   endtask

   // n = cycles from strobe edge to idle, counting the strobe edge; 200 means timed out.
   task automatic wait_idle(input bit w, input bit r, output int n);
      n = 1;
      while (!((!w || AMCI_WIDLE) && (!r || AMCI_RIDLE)) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic set_delays(input int aw, input int wd, input int b, input int ar, input int r);
      aw_delay = aw; w_delay = wd; b_delay = b; ar_delay = ar; r_delay = r;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY, AMCI_WIDLE, AMCI_RIDLE} !== 7'b0000011) begin
         errors++; $display("FAIL reset_ctrl: got %b, required 0000011",
                            {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY, AMCI_WIDLE, AMCI_RIDLE});
      end
      checks++;
      if ({AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AMCI_RDATA, AMCI_WRESP, AMCI_RRESP} !== 132'd0) begin
         errors++; $display("FAIL reset_data: got %h, required 0", {AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AMCI_RDATA, AMCI_WRESP, AMCI_RRESP});
      end
      checks++;
      if ({AXI_WSTRB, AXI_AWPROT, AXI_ARPROT} !== 10'b1111_000_000) begin
         errors++; $display("FAIL reset_const: got %b, required 1111000000", {AXI_WSTRB, AXI_AWPROT, AXI_ARPROT});
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_basic();
      int n, aw0, b0;
      set_delays(0, 0, 0, 0, 0);
      b_resp_val = 2'b00;
      aw0 = aw_hs; b0 = b_hs;
      exp_w.push_back({32'h0000_0010, 32'hCAFE_F00D, 2'b00});
      drive_cmd(1, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0);
      checks++;
      if ({AXI_AWVALID, AXI_WVALID, AMCI_WIDLE} !== 3'b110) begin
         errors++; $display("FAIL wr_valid_rise: AWVALID,WVALID,WIDLE=%b, required 110", {AXI_AWVALID, AXI_WVALID, AMCI_WIDLE});
      end
      wait_idle(1, 0, n);
      checks++;
      if (n != 3) begin errors++; $display("FAIL wr_latency: got %0d cycles, required 3", n); end
      e = exp_w.pop_front();
      checks++;
      if ({cap_awaddr, cap_wdata, cap_wstrb, cap_awprot, AMCI_WRESP} !== {e.addr, e.data, 4'hF, 3'b000, e.resp}) begin
         errors++; $display("FAIL wr_result: got %h/%h/%h/%b/%b, required %h/%h/f/000/%b",
                            cap_awaddr, cap_wdata, cap_wstrb, cap_awprot, AMCI_WRESP, e.addr, e.data, e.resp);
      end
      checks++;
      if ((aw_hs - aw0) != 1 || (b_hs - b0) != 1) begin
         errors++; $display("FAIL wr_handshakes: AW=%0d B=%0d, required 1 and 1", aw_hs - aw0, b_hs - b0);
      end
   endtask

   task automatic test_write_delayed();
      int n, b0;
      b_resp_val = 2'b00;
      for (int k = 0; k < 2; k++) begin
         set_delays(k == 0 ? 0 : 5, k == 0 ? 5 : 0, 0, 0, 0);
         b0 = b_hs;
         exp_w.push_back({32'h0000_0020 + 32'(k * 4), 32'h1357_0000 + 32'(k), 2'b00});
         drive_cmd(1, 0, 32'h0000_0020 + 32'(k * 4), 32'h1357_0000 + 32'(k), 32'h0);
         wait_idle(1, 0, n);
         checks++;
         if (n != 8) begin errors++; $display("FAIL wr_delayed_latency[%0d]: got %0d cycles, required 8", k, n); end
         e = exp_w.pop_front();
         checks++;
         if ({cap_awaddr, cap_wdata, AMCI_WRESP} !== {e.addr, e.data, e.resp}) begin
            errors++; $display("FAIL wr_delayed_result[%0d]: got %h/%h/%b, required %h/%h/%b",
                               k, cap_awaddr, cap_wdata, AMCI_WRESP, e.addr, e.data, e.resp);
         end
         checks++;
         if ((b_hs - b0) != 1) begin errors++; $display("FAIL wr_delayed_b[%0d]: got %0d B handshakes, required 1", k, b_hs - b0); end
      end
      checks++;
      if (mon_err != 0) begin errors++; $display("FAIL protocol_write: got %0d violations, required 0", mon_err); end
   endtask

   task automatic test_read();
      int n, r0;
      set_delays(0, 0, 0, 0, 4);
      r_data_val = 32'h1234_5678; r_resp_val = 2'b00;
      r0 = r_hs;
      exp_r.push_back({32'h0000_0004, 32'h1234_5678, 2'b00});
      drive_cmd(0, 1, 32'h0, 32'h0, 32'h0000_0004);
      checks++;
      if ({AXI_ARVALID, AMCI_RIDLE, AMCI_RDATA} !== {1'b1, 1'b0, 32'h0}) begin
         errors++; $display("FAIL rd_start: ARVALID=%b RIDLE=%b RDATA=%h, required 1 0 00000000", AXI_ARVALID, AMCI_RIDLE, AMCI_RDATA);
      end
      wait_idle(0, 1, n);
      checks++;
      if (n != 7) begin errors++; $display("FAIL rd_latency: got %0d cycles, required 7", n); end
      e = exp_r.pop_front();
      checks++;
      if ({cap_araddr, cap_arprot, AMCI_RDATA, AMCI_RRESP} !== {e.addr, 3'b000, e.data, e.resp}) begin
         errors++; $display("FAIL rd_result: got %h/%b/%h/%b, required %h/000/%h/%b",
                            cap_araddr, cap_arprot, AMCI_RDATA, AMCI_RRESP, e.addr, e.data, e.resp);
      end
      checks++;
      if ((r_hs - r0) != 1 || mon_err != 0) begin
         errors++; $display("FAIL rd_protocol: R handshakes=%0d violations=%0d, required 1 and 0", r_hs - r0, mon_err);
      end
   endtask

   task automatic test_error_resp();
      int n;
      set_delays(0, 0, 0, 0, 0);
      b_resp_val = 2'b10; r_resp_val = 2'b11; r_data_val = 32'hDEAD_BEEF;
      exp_w.push_back({32'h0000_0040, 32'h55AA_55AA, 2'b10});
      exp_r.push_back({32'h0000_0044, 32'hDEAD_BEEF, 2'b11});
      drive_cmd(1, 1, 32'h0000_0040, 32'h55AA_55AA, 32'h0000_0044);
      wait_idle(1, 1, n);
      checks++;
      if (n != 3) begin errors++; $display("FAIL err_latency: got %0d cycles, required 3", n); end
      e = exp_w.pop_front();
      checks++;
      if ({cap_awaddr, cap_wdata, AMCI_WRESP} !== {e.addr, e.data, e.resp}) begin
         errors++; $display("FAIL err_wresp: got %h/%h/%b, required %h/%h/%b", cap_awaddr, cap_wdata, AMCI_WRESP, e.addr, e.data, e.resp);
      end
      e = exp_r.pop_front();
      checks++;
      if ({cap_araddr, AMCI_RDATA, AMCI_RRESP} !== {e.addr, e.data, e.resp}) begin
         errors++; $display("FAIL err_rresp: got %h/%h/%b, required %h/%h/%b", cap_araddr, AMCI_RDATA, AMCI_RRESP, e.addr, e.data, e.resp);
      end
   endtask

   task automatic test_back_to_back();
      int n, aw0, ar0;
      set_delays(2, 1, 1, 1, 2);
      b_resp_val = 2'b01; r_resp_val = 2'b01; r_data_val = 32'hA5A5_0F0F;
      aw0 = aw_hs; ar0 = ar_hs;
      exp_w.push_back({32'h0000_0100, 32'h1111_1111, 2'b01});
      exp_r.push_back({32'h0000_0200, 32'hA5A5_0F0F, 2'b01});
      drive_cmd(1, 1, 32'h0000_0100, 32'h1111_1111, 32'h0000_0200);
      drive_cmd(1, 1, 32'h0000_0300, 32'h2222_2222, 32'h0000_0300);
      wait_idle(1, 1, n);
      checks++;
      if (n >= 200) begin errors++; $display("FAIL b2b_timeout: engines not idle after %0d cycles, required idle", n); end
      e = exp_w.pop_front();
      checks++;
      if ({cap_awaddr, cap_wdata, AMCI_WRESP} !== {e.addr, e.data, e.resp}) begin
         errors++; $display("FAIL b2b_write: got %h/%h/%b, required %h/%h/%b", cap_awaddr, cap_wdata, AMCI_WRESP, e.addr, e.data, e.resp);
      end
      e = exp_r.pop_front();
      checks++;
      if ({cap_araddr, AMCI_RDATA, AMCI_RRESP} !== {e.addr, e.data, e.resp}) begin
         errors++; $display("FAIL b2b_read: got %h/%h/%b, required %h/%h/%b", cap_araddr, AMCI_RDATA, AMCI_RRESP, e.addr, e.data, e.resp);
      end
      checks++;
      if ((aw_hs - aw0) != 1 || (ar_hs - ar0) != 1) begin
         errors++; $display("FAIL b2b_ignored: AW=%0d AR=%0d handshakes, required 1 and 1", aw_hs - aw0, ar_hs - ar0);
      end
      // a strobe issued in the first idle cycle must be taken
      set_delays(0, 0, 0, 0, 0);
      b_resp_val = 2'b00;
      aw0 = aw_hs;
      exp_w.push_back({32'h0000_0800, 32'h0BAD_C0DE, 2'b00});
      drive_cmd(1, 0, 32'h0000_0800, 32'h0BAD_C0DE, 32'h0);
      wait_idle(1, 0, n);
      e = exp_w.pop_front();
      checks++;
      if ({cap_awaddr, cap_wdata, AMCI_WRESP} !== {e.addr, e.data, e.resp}) begin
         errors++; $display("FAIL b2b_first: got %h/%h/%b, required %h/%h/%b", cap_awaddr, cap_wdata, AMCI_WRESP, e.addr, e.data, e.resp);
      end
      exp_w.push_back({32'h0000_0804, 32'h600D_F00D, 2'b00});
      drive_cmd(1, 0, 32'h0000_0804, 32'h600D_F00D, 32'h0);
      wait_idle(1, 0, n);
      e = exp_w.pop_front();
      checks++;
      if (n != 3 || (aw_hs - aw0) != 2 || {cap_awaddr, cap_wdata} !== {e.addr, e.data}) begin
         errors++; $display("FAIL b2b_immediate: latency=%0d AW=%0d addr/data=%h/%h, required 3, 2, %h/%h",
                            n, aw_hs - aw0, cap_awaddr, cap_wdata, e.addr, e.data);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      set_delays(50, 0, 0, 50, 0);
      drive_cmd(1, 1, 32'h0000_0500, 32'h0000_0077, 32'h0000_0600);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({AXI_AWVALID, AXI_ARVALID} !== 2'b11) begin
         errors++; $display("FAIL midrst_pending: AWVALID,ARVALID=%b, required 11", {AXI_AWVALID, AXI_ARVALID});
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY, AMCI_WIDLE, AMCI_RIDLE} !== 7'b0000011) begin
         errors++; $display("FAIL midrst_ctrl: got %b, required 0000011",
                            {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY, AMCI_WIDLE, AMCI_RIDLE});
      end
      checks++;
      if ({AMCI_RDATA, AMCI_WRESP, AMCI_RRESP} !== 36'd0) begin
         errors++; $display("FAIL midrst_amci: RDATA=%h WRESP=%b RRESP=%b, required 0", AMCI_RDATA, AMCI_WRESP, AMCI_RRESP);
      end
      reset = 1'b0;
      set_delays(0, 0, 0, 0, 0);
      b_resp_val = 2'b00;
      @(posedge clk); #1;
      exp_w.push_back({32'h0000_0700, 32'h89AB_CDEF, 2'b00});
      drive_cmd(1, 0, 32'h0000_0700, 32'h89AB_CDEF, 32'h0);
      wait_idle(1, 0, n);
      e = exp_w.pop_front();
      checks++;
      if (n != 3 || {cap_awaddr, cap_wdata, AMCI_WRESP} !== {e.addr, e.data, e.resp}) begin
         errors++; $display("FAIL midrst_recover: latency=%0d got %h/%h/%b, required 3 %h/%h/%b",
                            n, cap_awaddr, cap_wdata, AMCI_WRESP, e.addr, e.data, e.resp);
      end
      checks++;
      if (mon_err != 0) begin errors++; $display("FAIL protocol_all: got %0d violations, required 0", mon_err); end
   endtask

   initial begin
      checks = 0; errors = 0;
      reset = 1'b1;
      AMCI_WADDR = 0; AMCI_WDATA = 0; AMCI_RADDR = 0; AMCI_WRITE = 0; AMCI_READ = 0;
      set_delays(0, 0, 0, 0, 0);
      b_resp_val = 0; r_resp_val = 0; r_data_val = 0;
      test_reset();
      test_write_basic();
      test_write_delayed();
      test_read();
      test_error_resp();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
